// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// VGA raster timing generator for the pong display (640x480@60 by default).
// Divides the system clock into a one-clk pixel tick, then steps the
// horizontal and vertical position counters on each tick. The sync and blank
// outputs are decoded from the *next* counter values and registered, so they
// change on the same edge as pos_x/pos_y.
//
// Optional build macro:
//   VGA_SYNC_PIPE_EN - adds one pixel-tick-enabled register stage on hsync,
//                      vsync and video_on. They then lag pos_x/pos_y by one
//                      pixel, which lines them up with a registered colour
//                      stage downstream.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; low freezes the divider and the counters
//   pixel_tick  out  one-clk pulse per pixel advance
//   pos_x       out  horizontal count, 0..H_TOTAL-1
//   pos_y       out  vertical count, 0..V_TOTAL-1
//   video_on    out  high inside the active H_ACTIVE x V_ACTIVE area
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   frame_start out  one-clk pulse on the tick that loads position (0,0)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       pixel_tick,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             advance;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             von_nxt;

    // First-stage registered decode, aligned with pos_x/pos_y.
    logic             hs_r;
    logic             vs_r;
    logic             von_r;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign advance  = en && div_wrap;

    // Next position and the decode of that position.
    always_comb begin
        x_nxt   = pos_x;
        y_nxt   = pos_y;
        if (pos_x == H_LAST) begin
            x_nxt = 10'd0;
            y_nxt = (pos_y == V_LAST) ? 10'd0 : pos_y + 10'd1;
        end else begin
            x_nxt = pos_x + 10'd1;
        end
        hs_nxt  = !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vs_nxt  = !((y_nxt >= VS_START) && (y_nxt < VS_END));
        von_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            pos_x       <= H_LAST;
            pos_y       <= V_LAST;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            von_r       <= 1'b0;
        end else begin
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                if (div_wrap) begin
                    div_cnt     <= '0;
                    pixel_tick  <= 1'b1;
                    pos_x       <= x_nxt;
                    pos_y       <= y_nxt;
                    hs_r        <= hs_nxt;
                    vs_r        <= vs_nxt;
                    von_r       <= von_nxt;
                    frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    // Second stage loads on the same tick edge, so it captures the decode of
    // the pixel that is just being left: a one-pixel lag behind position.
    logic hs_p;
    logic vs_p;
    logic von_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p  <= 1'b1;
            vs_p  <= 1'b1;
            von_p <= 1'b0;
        end else if (advance) begin
            hs_p  <= hs_r;
            vs_p  <= vs_r;
            von_p <= von_r;
        end
    end

    assign hsync    = hs_p;
    assign vsync    = vs_p;
    assign video_on = von_p;
`else
    assign hsync    = hs_r;
    assign vsync    = vs_r;
    assign video_on = von_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// dut0 runs the default 640x480 timing with CLK_DIV=4 for reset, first pixel,
// line, enable-hold and asynchronous-reset scenarios. dut1 uses a tiny raster
// (16x13, CLK_DIV=1) so whole frames, vsync and the vertical wrap fit in a
// short run. Expected values come from the bench's own position model.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    // Small raster for dut1.
    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VA = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 16
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 13

    logic       clk;
    logic       rst_n;
    logic       en;

    logic       tick0, von0, hs0, vs0, fs0;
    logic [9:0] x0, y0;
    logic       tick1, von1, hs1, vs1, fs1;
    logic [9:0] x1, y1;

    int n_tests;
    int n_fail;

    // Bench model of dut0's position and of the pixel before it.
    int m_x, m_y, m_px, m_py;

    vga_sync_gen dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pixel_tick (tick0),
        .pos_x      (x0),
        .pos_y      (y0),
        .video_on   (von0),
        .hsync      (hs0),
        .vsync      (vs0),
        .frame_start(fs0)
    );

    vga_sync_gen #(
        .CLK_DIV (1),
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pixel_tick (tick1),
        .pos_x      (x1),
        .pos_y      (y1),
        .video_on   (von1),
        .hsync      (hs1),
        .vsync      (vs1),
        .frame_start(fs1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        en    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (x0 !== 10'd799 || y0 !== 10'd524) begin
            n_fail++;
            $display("FAIL reset_pos0: got (%0d,%0d) want (799,524)", x0, y0);
        end
        n_tests++;
        if ({tick0, fs0, von0, hs0, vs0} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_flags0: got tick/fs/von/hs/vs=%b want 00011",
                     {tick0, fs0, von0, hs0, vs0});
        end
        n_tests++;
        if (x1 !== 10'(S_HT - 1) || y1 !== 10'(S_VT - 1)) begin
            n_fail++;
            $display("FAIL reset_pos1: got (%0d,%0d) want (%0d,%0d)", x1, y1, S_HT - 1, S_VT - 1);
        end
    endtask

    // Release reset with en=1; (0,0) must appear on the 4th edge for dut0 and
    // on the 1st edge for dut1.
    task automatic test_first_pixel();
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            if (e == 1) begin
                n_tests++;
                if (tick1 !== 1'b1 || fs1 !== 1'b1 || x1 !== 10'd0 || y1 !== 10'd0) begin
                    n_fail++;
                    $display("FAIL first_pixel1: got tick=%b fs=%b pos=(%0d,%0d) want 1 1 (0,0)",
                             tick1, fs1, x1, y1);
                end
            end
            if (e < 4) begin
                n_tests++;
                if (tick0 !== 1'b0 || x0 !== 10'd799) begin
                    n_fail++;
                    $display("FAIL early_tick0 edge %0d: got tick=%b x=%0d want 0 799", e, tick0, x0);
                end
            end
        end
        n_tests++;
        if (tick0 !== 1'b1 || fs0 !== 1'b1 || x0 !== 10'd0 || y0 !== 10'd0) begin
            n_fail++;
            $display("FAIL first_pixel0: got tick=%b fs=%b pos=(%0d,%0d) want 1 1 (0,0)",
                     tick0, fs0, x0, y0);
        end
        n_tests++;
        if (hs0 !== 1'b1 || vs0 !== 1'b1 || von0 !== !PIPE) begin
            n_fail++;
            $display("FAIL first_sync0: got hs=%b vs=%b von=%b want 1 1 %b", hs0, vs0, von0, !PIPE);
        end
        m_x = 0; m_y = 0; m_px = 799; m_py = 524;
    endtask

    // Run from (0,0) to (0,1), checking every tick against the model.
    task automatic test_line();
        int since, guard, sx, sy;
        bit ehs, evon;
        since = 0;
        guard = 0;
        while (!(m_x == 0 && m_y == 1) && guard < 4000) begin
            @(negedge clk);
            guard++;
            since++;
            if (tick0) begin
                n_tests++;
                if (since != 4) begin
                    n_fail++;
                    $display("FAIL tick_period: got %0d clks want 4 at x=%0d", since, m_x);
                end
                since = 0;
                m_px = m_x; m_py = m_y;
                m_x++;
                if (m_x == 800) begin
                    m_x = 0;
                    m_y++;
                end
                sx   = PIPE ? m_px : m_x;
                sy   = PIPE ? m_py : m_y;
                ehs  = !(sx >= 656 && sx < 752);
                evon = (sx < 640) && (sy < 480);
                n_tests++;
                if (x0 !== 10'(m_x) || y0 !== 10'(m_y)) begin
                    n_fail++;
                    $display("FAIL line_pos: got (%0d,%0d) want (%0d,%0d)", x0, y0, m_x, m_y);
                end
                n_tests++;
                if (hs0 !== ehs || von0 !== evon || vs0 !== 1'b1 || fs0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL line_sync x=%0d: got hs=%b von=%b vs=%b fs=%b want %b %b 1 0",
                             m_x, hs0, von0, vs0, fs0, ehs, evon);
                end
            end
        end
        n_tests++;
        if (guard >= 4000) begin
            n_fail++;
            $display("FAIL line_timeout: got model at (%0d,%0d) want (0,1)", m_x, m_y);
        end
    endtask

    // Freeze for 37 clks with div_cnt=1; three more enabled edges give x=301.
    task automatic test_en_hold();
        int guard;
        int bad;
        guard = 0;
        while (m_x != 300 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (tick0) begin
                m_px = m_x; m_py = m_y;
                m_x++;
            end
        end
        n_tests++;
        if (x0 !== 10'd300 || y0 !== 10'd1) begin
            n_fail++;
            $display("FAIL hold_setup: got (%0d,%0d) want (300,1)", x0, y0);
        end
        @(negedge clk);
        en  = 1'b0;
        bad = 0;
        repeat (37) begin
            @(negedge clk);
            if (tick0 !== 1'b0 || x0 !== 10'd300) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_frozen: got %0d bad clks want 0", bad);
        end
        en = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            n_tests++;
            if (tick0 !== (e == 3)) begin
                n_fail++;
                $display("FAIL resume_tick edge %0d: got %b want %b", e, tick0, e == 3);
            end
        end
        n_tests++;
        if (x0 !== 10'd301) begin
            n_fail++;
            $display("FAIL resume_pos: got x=%0d want 301", x0);
        end
        m_px = 300; m_x = 301;
    endtask

    // Reset between edges at (400,1); outputs must change before any edge.
    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (m_x != 400 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (tick0) m_x++;
        end
        n_tests++;
        if (x0 !== 10'd400) begin
            n_fail++;
            $display("FAIL areset_setup: got x=%0d want 400", x0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (x0 !== 10'd799 || y0 !== 10'd524 || von0 !== 1'b0 || hs0 !== 1'b1 || vs0 !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_now: got pos=(%0d,%0d) von=%b hs=%b vs=%b want (799,524) 0 1 1",
                     x0, y0, von0, hs0, vs0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tick0 !== 1'b0 || x0 !== 10'd799) begin
            n_fail++;
            $display("FAIL areset_early: got tick=%b x=%0d want 0 799", tick0, x0);
        end
        @(negedge clk);
        n_tests++;
        if (tick0 !== 1'b1 || fs0 !== 1'b1 || x0 !== 10'd0 || y0 !== 10'd0) begin
            n_fail++;
            $display("FAIL areset_restart: got tick=%b fs=%b pos=(%0d,%0d) want 1 1 (0,0)",
                     tick0, fs0, x0, y0);
        end
    endtask

    // Two full frames on the small raster: vsync, wrap and frame spacing.
    task automatic test_frame();
        int x, y, px, py, sx, sy, cyc, last_fs, n_fs;
        bit ehs, evs, evon, efs;
        do_reset();
        x = S_HT - 1; y = S_VT - 1;
        cyc = 0; last_fs = -1; n_fs = 0;
        repeat (2 * S_HT * S_VT + 1) begin
            @(negedge clk);
            cyc++;
            px = x; py = y;
            x++;
            if (x == S_HT) begin
                x = 0;
                y = (y == S_VT - 1) ? 0 : y + 1;
            end
            sx   = PIPE ? px : x;
            sy   = PIPE ? py : y;
            ehs  = !(sx >= S_HA + S_HF && sx < S_HA + S_HF + S_HS);
            evs  = !(sy >= S_VA + S_VF && sy < S_VA + S_VF + S_VS);
            evon = (sx < S_HA) && (sy < S_VA);
            efs  = (x == 0) && (y == 0);
            n_tests++;
            if (tick1 !== 1'b1 || x1 !== 10'(x) || y1 !== 10'(y)) begin
                n_fail++;
                $display("FAIL frame_pos: got tick=%b (%0d,%0d) want 1 (%0d,%0d)", tick1, x1, y1, x, y);
            end
            n_tests++;
            if (hs1 !== ehs || vs1 !== evs || von1 !== evon || fs1 !== efs) begin
                n_fail++;
                $display("FAIL frame_sync (%0d,%0d): got hs=%b vs=%b von=%b fs=%b want %b %b %b %b",
                         x, y, hs1, vs1, von1, fs1, ehs, evs, evon, efs);
            end
            if (fs1 === 1'b1) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_tests++;
                    if (cyc - last_fs != S_HT * S_VT) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d clks want %0d", cyc - last_fs, S_HT * S_VT);
                    end
                end
                last_fs = cyc;
            end
        end
        n_tests++;
        if (n_fs != 3) begin
            n_fail++;
            $display("FAIL frame_count: got %0d frame_start pulses want 3", n_fs);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_first_pixel();
        test_line();
        test_en_hold();
        test_async_reset();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
